// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD read sequencer
package sd_pkg;
  localparam int SD_WORD_W = 32;
  localparam int SD_BLOCK_BYTES = 512;
  localparam int DEF_WORDS_PER_BLOCK = SD_BLOCK_BYTES / (SD_WORD_W / 8);
  typedef enum logic [2:0] {IDLE, SETADDR, READ, DRAIN, FINISH} state_e;
endpackage

// File: rtl/sd_word_fifo.sv
// sd_word_fifo: DEPTH x word synchronous FIFO, head word always visible on data_o
module sd_word_fifo import sd_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [SD_WORD_W-1:0]   data_i,
  output logic [SD_WORD_W-1:0]   data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [SD_WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign data_o = mem_q[rd_q];
  assign rd = pop_i & ~empty_o;
  // a push into a full FIFO is legal only when the head leaves in the same cycle
  assign wr = push_i & (~full_o | rd);
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) mem_q[wr_q] <= data_i;
      wr_q <= wr_q + AW'(wr);
      rd_q <= rd_q + AW'(rd);
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/sd_read_sequencer.sv
// sd_read_sequencer: issues one set-address then streams helper words through a
// small buffer, reading the helper only when the buffer can take the word.
module sd_read_sequencer import sd_pkg::*; #(
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int CNT_W = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SD_WORD_W-1:0] req_addr,
  input  logic [CNT_W-1:0]     req_blocks,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SD_WORD_W-1:0] out_data,
  output logic                 done,
  output logic                 sd_set_addr,
  output logic [SD_WORD_W-1:0] sd_addr,
  output logic                 sd_ren,
  input  logic [SD_WORD_W-1:0] sd_data
);
  localparam int REM_W = CNT_W + $clog2(WORDS_PER_BLOCK);
  localparam int AW = $clog2(BUF_DEPTH);
  state_e state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [SD_WORD_W-1:0] addr_q, addr_d;
  logic [AW:0] count;
  logic full, empty, pop;
  sd_word_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push_i(sd_ren), .pop_i(out_ready), .data_i(sd_data),
    .data_o(out_data), .count_o(count), .full_o(full), .empty_o(empty)
  );
  assign out_valid = ~empty;
  assign pop = out_valid & out_ready;
  assign sd_addr = addr_q;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    addr_d = addr_q;
    req_ready = state_q == IDLE;
    sd_set_addr = state_q == SETADDR;
    done = state_q == FINISH;
    // occupancy after this cycle's pop stays below depth
    sd_ren = state_q == READ && rem_q != '0 && (!full || pop);
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d = req_addr;
        rem_d = REM_W'(req_blocks) * REM_W'(WORDS_PER_BLOCK);
        state_d = req_blocks == '0 ? FINISH : SETADDR;
      end
      SETADDR: state_d = READ;
      READ: begin
        rem_d = rem_q - REM_W'(sd_ren);
        state_d = rem_d == '0 ? DRAIN : READ;
      end
      DRAIN: state_d = (empty || (count == (AW+1)'(1) && pop)) ? FINISH : DRAIN;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: tb/tb_sd_read_sequencer.sv
// tb_sd_read_sequencer: directed vector table plus hand-written corner sequences
module tb_sd_read_sequencer;
  logic clk = 0, reset = 1, req_valid = 0, req_ready, out_valid, out_ready = 1;
  logic done, sd_set_addr, sd_ren;
  logic [31:0] req_addr = 0, out_data, sd_addr, sd_data, hptr = 0, exp_base = 0;
  logic [15:0] req_blocks = 0;
  int tests = 0, fails = 0, mode = 0;
  int cyc = 0, n_set = 0, n_ren = 0, n_done = 0, n_words = 0, seq_err = 0, stab_err = 0;
  int widx = 0, acc_cyc = 0, first_cyc = 0, done_cyc = 0, last_hs = 0;
  logic first_pend = 0, prev_stall = 0;
  logic [31:0] prev_data = 0;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] blocks;
    int mode;
    int sets;
    int rens;
    int words;
    int dones;
  } vec_t;
  vec_t vecs [4];

  sd_read_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_blocks(req_blocks), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .done(done),
    .sd_set_addr(sd_set_addr), .sd_addr(sd_addr), .sd_ren(sd_ren), .sd_data(sd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A00_00C3;
  endfunction

  assign sd_data = word(hptr);
  always @(posedge clk)
    if (sd_set_addr) hptr <= sd_addr;
    else if (sd_ren) hptr <= hptr + 32'd4;

  always @(negedge clk) begin
    cyc++;
    if (sd_set_addr) n_set++;
    if (sd_ren) n_ren++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (first_pend && out_valid) begin first_cyc = cyc; first_pend = 0; end
    if (req_valid && req_ready) begin acc_cyc = cyc; widx = 0; first_pend = 1; end
    if (prev_stall && out_data !== prev_data) stab_err++;
    if (out_valid && out_ready) begin
      if (out_data !== word(exp_base + 32'(widx) * 32'd4)) seq_err++;
      widx++;
      n_words++;
      last_hs = cyc;
    end
    prev_stall = out_valid && !out_ready && !reset;
    prev_data = out_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mode == 2) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic rst_chk(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_set_addr"}, 32'(sd_set_addr), 0);
    check({tag, "_sd_addr"}, sd_addr, 0);
    check({tag, "_sd_ren"}, 32'(sd_ren), 0);
  endtask

  task automatic run(input vec_t v, input string tag);
    int s0, r0, w0, d0, q0, st0, t;
    s0 = n_set; r0 = n_ren; w0 = n_words; d0 = n_done; q0 = seq_err; st0 = stab_err;
    exp_base = v.addr;
    mode = v.mode;
    out_ready = v.mode != 1;
    t = 0;
    while (!req_ready && t < 100) begin tick(); t++; end
    req_valid = 1; req_addr = v.addr; req_blocks = v.blocks;
    tick();
    req_valid = 0;
    if (v.mode == 1) begin
      repeat (19) tick();
      check({tag, "_stall_rens"}, 32'(n_ren - r0), 4);
      out_ready = 1;
    end
    t = 0;
    while (n_done == d0 && t < 5000) begin tick(); t++; end
    mode = 0;
    out_ready = 1;
    check({tag, "_sets"}, 32'(n_set - s0), 32'(v.sets));
    check({tag, "_rens"}, 32'(n_ren - r0), 32'(v.rens));
    check({tag, "_words"}, 32'(n_words - w0), 32'(v.words));
    check({tag, "_dones"}, 32'(n_done - d0), 32'(v.dones));
    check({tag, "_order_errs"}, 32'(seq_err - q0), 0);
    check({tag, "_stable_errs"}, 32'(stab_err - st0), 0);
    check({tag, "_done_lat"}, 32'(done_cyc), 32'(v.words == 0 ? acc_cyc + 1 : last_hs + 1));
    if (v.mode == 0 && v.blocks != 0) check({tag, "_first_lat"}, 32'(first_cyc - acc_cyc), 3);
    check({tag, "_idle_after"}, 32'(req_ready), 1);
  endtask

  initial begin
    int w0, d0, s0, q0, t, dc1;
    vec_t rv;
    vecs[0] = '{32'h0000_0200, 16'd1, 0, 1, 128, 128, 1};
    vecs[1] = '{32'h0000_0300, 16'd0, 0, 0, 0, 0, 1};
    vecs[2] = '{32'h0000_1000, 16'd1, 1, 1, 128, 128, 1};
    vecs[3] = '{32'h0000_8000, 16'd3, 2, 1, 384, 384, 1};
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rst_chk("init");
    for (int i = 0; i < 4; i++) run(vecs[i], $sformatf("v%0d", i));

    // request held valid through a transfer with a different (zero-block) request
    s0 = n_set; w0 = n_words; d0 = n_done; q0 = seq_err;
    exp_base = 32'h2000;
    req_valid = 1; req_addr = 32'h2000; req_blocks = 16'd1;
    tick();
    req_addr = 32'h5000; req_blocks = 16'd0;
    t = 0;
    while (n_done == d0 && t < 2000) begin tick(); t++; end
    dc1 = done_cyc;
    check("held_ready_after_done", 32'(req_ready), 1);
    tick();
    req_valid = 0;
    tick();
    check("held_sets", 32'(n_set - s0), 1);
    check("held_words", 32'(n_words - w0), 128);
    check("held_order_errs", 32'(seq_err - q0), 0);
    check("held_dones", 32'(n_done - d0), 2);
    check("held_second_done_lat", 32'(done_cyc - dc1), 2);

    // reset in the middle of a block, then restart elsewhere
    w0 = n_words; d0 = n_done;
    exp_base = 32'h3000;
    req_valid = 1; req_addr = 32'h3000; req_blocks = 16'd1;
    tick();
    req_valid = 0;
    t = 0;
    while (n_words - w0 < 50 && t < 500) begin tick(); t++; end
    check("midrst_reached_50", 32'(n_words - w0 >= 50), 1);
    reset = 1;
    tick();
    reset = 0;
    rst_chk("midrst");
    repeat (5) tick();
    check("midrst_no_done", 32'(n_done - d0), 0);
    rv = '{32'h0000_0400, 16'd1, 0, 1, 128, 128, 1};
    run(rv, "restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
